std_mem_d1_arbiter: RTL and testbench

// Shares one std_mem_d1 single-port memory between NUM_REQ requesters using the go/done handshake.
// It registers the winning request and drives the memory port, then returns done plus read data to the winner.
// It sits between the generated component control and the memory instance.

---
 rtl/std_mem_d1_arbiter.sv | 166 ++++++++++++++++
 tb/tb_std_mem_d1_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_mem_d1_arbiter.sv
// std_mem_d1_arbiter: shares one std_mem_d1 single-port memory between
// NUM_REQ requesters using the go/done handshake. A winning request is
// latched in IDLE, issued to the memory, and answered with a one-cycle
// done pulse (plus read data for reads).
// Build option: define STD_MEM_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); the default build is round-robin.
module std_mem_d1_arbiter #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4,
  parameter int NUM_REQ  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_go,
  input  logic [NUM_REQ*IDX_SIZE-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     req_write_data,
  input  logic [NUM_REQ-1:0]           req_write_en,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [WIDTH-1:0]             req_read_data,
  output logic                         busy,
  output logic [IDX_SIZE-1:0]          mem_addr0,
  output logic [WIDTH-1:0]             mem_write_data,
  output logic                         mem_write_en,
  input  logic [WIDTH-1:0]             mem_read_data,
  input  logic                         mem_done
);

  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic                 found;
  logic                 load;
  logic [NUM_REQ-1:0]   mask_q;
  logic [NUM_REQ-1:0]   cand;
  logic [IDX_SIZE-1:0]  addr_q, sel_addr;
  logic [WIDTH-1:0]     wdata_q, sel_wdata;
  logic                 we_q, sel_we;
  logic [WIDTH-1:0]     rdata_q;

  // The requester served in RESP is excluded for the single IDLE cycle after it
  assign cand = req_go & ~mask_q;

`ifdef STD_MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest candidate index wins
  always_comb begin
    grant_d = grant_q;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[GRANT_W'(i)]) begin
        found   = 1'b1;
        grant_d = GRANT_W'(i);
      end
    end
  end
`else
  logic [GRANT_W-1:0] last_grant_q;
  logic [GRANT_W-1:0] rr_idx;

  // Round-robin: search from last_grant+1, wrapping at NUM_REQ
  always_comb begin
    grant_d = grant_q;
    found   = 1'b0;
    rr_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_idx = GRANT_W'((32'(last_grant_q) + i) % 32'(NUM_REQ));
      if (!found && cand[rr_idx]) begin
        found   = 1'b1;
        grant_d = rr_idx;
      end
    end
  end

  // Remember the last served requester; reset gives requester 0 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
    end else if (state_q == S_RESP) begin
      last_grant_q <= grant_q;
    end
  end
`endif

  // Select the winning requester's packed slices
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_d == GRANT_W'(i)) begin
        sel_addr  = req_addr[i*IDX_SIZE +: IDX_SIZE];
        sel_wdata = req_write_data[i*WIDTH +: WIDTH];
        sel_we    = req_write_en[i];
      end
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> (WAIT) -> RESP sequence
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_ISSUE;
          load    = 1'b1;
        end
      end
      S_ISSUE: state_d = we_q ? S_WAIT : S_RESP;
      S_WAIT:  if (mem_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears them without a clock edge
  always_comb begin
    req_done       = '0;
    busy           = (state_q != S_IDLE);
    mem_write_en   = (state_q == S_ISSUE) && we_q;
    mem_addr0      = '0;
    mem_write_data = '0;
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      mem_addr0      = addr_q;
      mem_write_data = wdata_q;
    end
    if (state_q == S_RESP) begin
      req_done[grant_q] = 1'b1;
    end
  end

  assign req_read_data = rdata_q;

  // State register, latched request, read capture and post-done mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= req_done;
      if (load) begin
        grant_q <= grant_d;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        we_q    <= sel_we;
      end
      if (state_q == S_ISSUE && !we_q) begin
        rdata_q <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
// Self-checking bench for std_mem_d1_arbiter: a transaction-level model
// predicts each grant, its timing and its data; directed sequences cover
// reset, handshake latency, arbitration order and late request changes.
module tb_std_mem_d1_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IW   = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_go;
  logic [NREQ*IW-1:0]   req_addr;
  logic [NREQ*W-1:0]    req_write_data;
  logic [NREQ-1:0]      req_write_en;
  logic [NREQ-1:0]      req_done;
  logic [W-1:0]         req_read_data;
  logic                 busy;
  logic [IW-1:0]        mem_addr0;
  logic [W-1:0]         mem_write_data;
  logic                 mem_write_en;
  logic [W-1:0]         mem_read_data;
  logic                 mem_done;

  std_mem_d1_arbiter #(.WIDTH(W), .IDX_SIZE(IW), .NUM_REQ(NREQ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_go         (req_go),
    .req_addr       (req_addr),
    .req_write_data (req_write_data),
    .req_write_en   (req_write_en),
    .req_done       (req_done),
    .req_read_data  (req_read_data),
    .busy           (busy),
    .mem_addr0      (mem_addr0),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .mem_done       (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on edge, done mem_delay cycles after write_en
  logic [W-1:0] mem [16];
  int unsigned  mem_delay = 1;
  int unsigned  done_cnt;
  int unsigned  wr_count = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (mem_write_en) begin
      mem[mem_addr0] <= mem_write_data;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_cnt <= 0;
    else if (mem_write_en) done_cnt <= mem_delay;
    else if (done_cnt != 0) done_cnt <= done_cnt - 1;
  end

  always @(posedge clk) if (mem_write_en) wr_count <= wr_count + 1;

  assign mem_done      = (done_cnt == 1);
  assign mem_read_data = mem[mem_addr0];

  // Requester drive state
  logic [NREQ-1:0] d_go, d_we;
  logic [IW-1:0]   d_addr [NREQ];
  logic [W-1:0]    d_data [NREQ];
  bit              pend   [NREQ];
  int              lcnt   [NREQ];
  bit              auto_mode, allow_new;

  // Transaction-level reference model
  int           k;
  bit           have_txn;
  int           t_grant, t_done, win, last_win;
  bit           m_we;
  logic [IW-1:0] m_addr;
  logic [W-1:0] m_data, m_rdata, rd_exp;
  logic [W-1:0] shadow [16];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, k);
  endtask

  function automatic int pick(input logic [NREQ-1:0] c);
`ifdef STD_MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (c[i]) return i;
`else
    for (int i = last_win + 1; i < NREQ; i++) if (c[i]) return i;
    for (int i = 0; i <= last_win; i++) if (c[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    have_txn = 1'b0;
    last_win = NREQ - 1;
    rd_exp   = '0;
    t_grant  = 0;
    t_done   = 0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_go[i]                  = d_go[i];
      req_write_en[i]            = d_we[i];
      req_addr[i*IW +: IW]       = d_addr[i];
      req_write_data[i*W +: W]   = d_data[i];
    end
  endtask

  // One cycle: check outputs, update stimulus, let the model sample IDLE
  task automatic step();
    logic [NREQ-1:0] ed, cand;
    bit acc;
    @(negedge clk);
    k++;
    ed = '0;
    if (have_txn && k == t_done) ed[win] = 1'b1;
    if (have_txn && !m_we && k == t_grant + 2) rd_exp = m_rdata;
    acc = have_txn && k > t_grant && k < t_done;
    chk("done",  32'(req_done), 32'(ed));
    chk("busy",  32'(busy), 32'(have_txn && k > t_grant && k <= t_done));
    chk("wen",   32'(mem_write_en), 32'(have_txn && m_we && k == t_grant + 1));
    chk("addr",  32'(mem_addr0), acc ? 32'(m_addr) : 32'd0);
    chk("wdata", mem_write_data, acc ? m_data : 32'd0);
    chk("rdata", req_read_data, rd_exp);
    if (auto_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_done[i]) begin
          pend[i] = 1'b0;
          if ($urandom_range(1, 0) == 1) lcnt[i] = 2;
          else d_go[i] = 1'b0;
        end else if (lcnt[i] > 1) begin
          lcnt[i]--;
        end else if (lcnt[i] == 1) begin
          lcnt[i] = 0;
          d_go[i] = 1'b0;
        end else if (!pend[i] && allow_new && $urandom_range(3, 0) == 0) begin
          pend[i]   = 1'b1;
          d_go[i]   = 1'b1;
          d_we[i]   = 1'($urandom_range(1, 0));
          d_addr[i] = IW'($urandom_range(7, 0));
          d_data[i] = $urandom;
        end else if (pend[i] && $urandom_range(7, 0) == 0) begin
          d_addr[i] = IW'($urandom_range(7, 0));
          d_data[i] = $urandom;
        end
      end
    end
    apply();
    if (!have_txn || k > t_done) begin
      cand = req_go;
      if (have_txn && k == t_done + 1) cand[win] = 1'b0;
      if (cand != '0) begin
        win      = pick(cand);
        last_win = win;
        have_txn = 1'b1;
        t_grant  = k;
        m_we     = d_we[win];
        m_addr   = d_addr[win];
        m_data   = d_data[win];
        if (m_we) begin
          shadow[m_addr] = m_data;
          t_done = k + 2 + int'(mem_delay);
        end else begin
          m_rdata = shadow[m_addr];
          t_done  = k + 2;
        end
      end
    end
  endtask

  task automatic drain();
    bit idle;
    allow_new = 1'b0;
    idle = 1'b0;
    for (int n = 0; n < 300; n++) begin
      idle = (d_go == '0) && (!have_txn || k > t_done);
      if (idle) break;
      step();
    end
    chk("drain_idle", 32'(idle), 32'd1);
  endtask

  task automatic do_req(input int i, input bit we, input logic [IW-1:0] a, input logic [W-1:0] dat);
    bit seen;
    d_go[i] = 1'b1; d_we[i] = we; d_addr[i] = a; d_data[i] = dat;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (req_done[i]) begin seen = 1'b1; break; end
    end
    chk("req_done_seen", 32'(seen), 32'd1);
    d_go[i] = 1'b0;
  endtask

  initial begin
    int first;
    bit seen;
    int unsigned wc0;
    rst_n = 1'b0;
    k = 0;
    auto_mode = 1'b0;
    allow_new = 1'b0;
    d_go = '0; d_we = '0;
    for (int i = 0; i < NREQ; i++) begin
      d_addr[i] = '0; d_data[i] = '0; pend[i] = 1'b0; lcnt[i] = 0;
    end
    apply();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(req_done), 32'd0);
    chk("rst_wen",   32'(mem_write_en), 32'd0);
    chk("rst_addr",  32'(mem_addr0), 32'd0);
    chk("rst_rdata", req_read_data, 32'd0);
    rst_n = 1'b1;

    // Reset asserted while a slow write sits in WAIT
    mem_delay = 3;
    d_go[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 4'd3; d_data[1] = 32'hA5A5_0001;
    repeat (3) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy",  32'(busy), 32'd0);
    chk("async_addr",  32'(mem_addr0), 32'd0);
    chk("async_wdata", mem_write_data, 32'd0);
    chk("async_wen",   32'(mem_write_en), 32'd0);
    chk("async_done",  32'(req_done), 32'd0);
    d_go = '0;
    apply();
    model_reset();
    mem_delay = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Tie between requesters 0 and 1 right after reset
    d_go[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 4'd1;
    d_go[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 4'd2;
    first = -1;
    for (int n = 0; n < 40 && d_go != '0; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (req_done[i]) begin
          if (first < 0) first = i;
          d_go[i] = 1'b0;
        end
      end
    end
    chk("tie_first", 32'(first), 32'd0);
    drain();

    // Write then read back through different requesters
    do_req(1, 1'b1, 4'd3, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 4'd3, 32'h0);
    chk("readback", req_read_data, 32'hDEAD_BEEF);
    drain();

    // All requesters hold read go
    for (int i = 0; i < NREQ; i++) begin
      d_go[i] = 1'b1; d_we[i] = 1'b0; d_addr[i] = IW'(i);
    end
    repeat (20) step();
    d_go = '0;
    drain();

    // Requester 2 drops go (and scrambles its request) right after the latch
    step();
    d_go[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 4'd5; d_data[2] = 32'h1234_5678;
    wc0 = wr_count;
    step();
    d_go[2] = 1'b0; d_addr[2] = 4'd9; d_data[2] = 32'hFFFF_0000;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (req_done[2]) begin seen = 1'b1; break; end
    end
    chk("drop_done", 32'(seen), 32'd1);
    drain();
    chk("single_access", wr_count - wc0, 32'd1);

    // Slow memory: done three cycles after write_en
    mem_delay = 3;
    do_req(3, 1'b1, 4'd7, 32'hCAFE_F00D);
    drain();
    do_req(1, 1'b0, 4'd7, 32'h0);
    chk("slow_readback", req_read_data, 32'hCAFE_F00D);
    drain();

    // Randomized traffic at each memory latency
    for (int ph = 1; ph <= 3; ph++) begin
      mem_delay = ph;
      auto_mode = 1'b1;
      allow_new = 1'b1;
      repeat (250) step();
      drain();
      auto_mode = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
